// File: rtl/sqrt_client.sv
// Sweep engine for the integer square-root unit: issues one start/ack request per
// operand in [a_first, a_last], checks each result and reports errors and timeouts.
module sqrt_client #(
    parameter int AW      = 8,
    parameter int RW      = AW / 2,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          run,
    input  logic [AW-1:0] a_first,
    input  logic [AW-1:0] a_last,
    output logic [AW-1:0] A,
    output logic          start,
    input  logic          ack,
    input  logic [RW-1:0] I,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] err_count,
    output logic [AW-1:0] last_bad_a,
    output logic          timeout_flag
);

    localparam int PW = 2 * RW + 1;
    localparam int CW = $clog2(TIMEOUT + GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ACCEPT, S_WAIT, S_CHECK, S_GAP, S_FIN
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] a_next, a_end, a_end_next, err_next, bad_next;
    logic [RW-1:0] result, result_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          to_next;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (&v) ? v : v + AW'(1);
    endfunction

    // One extra product bit so that (2^RW)^2 is representable.
    function automatic logic root_ok(input logic [RW-1:0] r, input logic [AW-1:0] a);
        logic [PW-1:0] r_lo, r_hi, a_ext;
        r_lo  = PW'(r);
        r_hi  = r_lo + PW'(1);
        a_ext = PW'(a);
        return (r_lo * r_lo <= a_ext) && (r_hi * r_hi > a_ext);
    endfunction

    always_comb begin
        state_next  = state;
        a_next      = A;
        a_end_next  = a_end;
        err_next    = err_count;
        bad_next    = last_bad_a;
        to_next     = timeout_flag;
        cnt_next    = cnt;
        result_next = result;
        case (state)
            S_IDLE: begin
                if (run) begin
                    a_next     = a_first;
                    a_end_next = a_last;
                    err_next   = '0;
                    bad_next   = '0;
                    to_next    = 1'b0;
                    state_next = S_REQ;
                end
            end
            S_REQ: state_next = S_ACCEPT;
            S_ACCEPT: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (ack) begin
                    result_next = I;
                    state_next  = S_CHECK;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    to_next    = 1'b1;
                    state_next = S_FIN;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_CHECK: begin
                if (!root_ok(result, A)) begin
                    err_next = sat_inc(err_count);
                    bad_next = A;
                end
                cnt_next = '0;
                // ">=" also covers a_first > a_last: one request, no wrap.
                if (A >= a_end) begin
                    state_next = S_FIN;
                end else begin
                    a_next     = A + AW'(1);
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP - 1)) state_next = S_REQ;
                else cnt_next = cnt + CW'(1);
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= S_IDLE;
            A            <= '0;
            start        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_count    <= '0;
            last_bad_a   <= '0;
            timeout_flag <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_next;
            A            <= a_next;
            start        <= (state_next == S_REQ);
            busy         <= (state_next != S_IDLE) && (state_next != S_FIN);
            done         <= (state_next == S_FIN);
            err_count    <= err_next;
            last_bad_a   <= bad_next;
            timeout_flag <= to_next;
            cnt          <= cnt_next;
        end
    end

    always_ff @(posedge Clk) begin
        a_end  <= a_end_next;
        result <= result_next;
    end

endmodule
